// File: rtl/uart_block_rx_if.sv
// rtl/uart_block_rx_if.sv - serial input and block-capture outputs of the UART block receiver
interface uart_block_rx_if #(
    parameter int BYTES = 48
);
    logic                 rx;
    logic [8*BYTES-1:0]   block_data;
    logic                 block_valid;
    logic [7:0]           byte_cnt;
    logic                 frame_err;
    logic                 timeout;

    // Receiver side: consumes the serial line, produces the assembled block
    modport master (
        input  rx,
        output block_data,
        output block_valid,
        output byte_cnt,
        output frame_err,
        output timeout
    );

    // Host side: drives the serial line, observes the block
    modport slave (
        output rx,
        input  block_data,
        input  block_valid,
        input  byte_cnt,
        input  frame_err,
        input  timeout
    );
endinterface

// File: rtl/uart_block_rx.sv
// rtl/uart_block_rx.sv - 8N1 UART receiver assembling BYTES bytes into one block; UART_RX_PARITY_EN selects 8E1
module uart_block_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int BYTES     = 48,
    parameter int IDLE_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    uart_block_rx_if.master   bus
);
    localparam int CPB        = CLK_FREQ / BAUD;
    localparam int HALF       = CPB / 2;
    localparam int BAUD_W     = $clog2(CPB);
    localparam int IDLE_LIMIT = IDLE_BITS * CPB;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT);
    localparam int BLK_W      = 8 * BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BAUD_W-1:0]   baud_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q;
`ifdef UART_RX_PARITY_EN
    logic                parity_q;
`endif
    logic [BLK_W-1:0]    block_buf_q;
    logic [BLK_W-1:0]    block_data_q;
    logic                block_valid_q;
    logic [7:0]          byte_cnt_q;
    logic                frame_err_q;
    logic                timeout_q;
    logic [IDLE_W-1:0]   idle_cnt_q;

    logic                start_edge;
    logic                baud_hit;
    logic                parity_ok;
    logic                stop_sample;
    logic                byte_ok;
    logic                byte_bad;
    logic                timeout_hit;

    // START waits only half a bit so every later sample lands mid-bit
    assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_sync_q;
    assign baud_hit   = (state_q == S_START) ? (baud_cnt_q == BAUD_W'(HALF - 1))
                                             : (baud_cnt_q == BAUD_W'(CPB - 1));

    // Two-flop synchroniser plus previous value for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge) state_d = S_START;
            S_START:  if (baud_hit)   state_d = rx_sync_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (baud_hit && bit_cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (baud_hit)   state_d = S_STOP;
`else
            S_DATA:   if (baud_hit && bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
            S_STOP:   if (baud_hit)   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: byte verdict at the stop sample and idle-timeout strobe
    always_comb begin
        parity_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_ok = ((^shift_q) ^ parity_q) == 1'b0;
`endif
        stop_sample = (state_q == S_STOP) && baud_hit;
        byte_ok     = stop_sample && rx_sync_q && parity_ok;
        byte_bad    = stop_sample && !(rx_sync_q && parity_ok);
        timeout_hit = (state_q == S_IDLE) && (byte_cnt_q != 8'd0) && !start_edge
                      && (idle_cnt_q == IDLE_W'(IDLE_LIMIT - 1));
    end

    // Bit timing and data deserialisation, LSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            if (state_q == S_IDLE || baud_hit) baud_cnt_q <= '0;
            else                               baud_cnt_q <= baud_cnt_q + BAUD_W'(1);

            if (state_q == S_IDLE) begin
                bit_cnt_q <= 3'd0;
            end else if (state_q == S_DATA && baud_hit) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {rx_sync_q, shift_q[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the received parity bit for checking at the stop sample
    always_ff @(posedge clk) begin
        if (rst)                                  parity_q <= 1'b0;
        else if (state_q == S_PARITY && baud_hit) parity_q <= rx_sync_q;
    end
`endif

    // Block assembly, completion pulse, error and timeout pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            block_buf_q   <= '0;
            block_data_q  <= '0;
            block_valid_q <= 1'b0;
            byte_cnt_q    <= 8'd0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            block_valid_q <= 1'b0;
            frame_err_q   <= byte_bad;
            timeout_q     <= 1'b0;
            if (byte_ok) begin
                block_buf_q <= {block_buf_q[BLK_W-9:0], shift_q};
                if (byte_cnt_q == 8'(BYTES - 1)) begin
                    block_data_q  <= {block_buf_q[BLK_W-9:0], shift_q};
                    block_valid_q <= 1'b1;
                    byte_cnt_q    <= 8'd0;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                end
            end else if (timeout_hit) begin
                block_buf_q <= '0;
                byte_cnt_q  <= 8'd0;
                timeout_q   <= 1'b1;
            end
        end
    end

    // Idle timer runs only between bytes of a partial block; a start edge restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else if (state_q == S_IDLE && byte_cnt_q != 8'd0 && !start_edge && !timeout_hit) begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
        end else begin
            idle_cnt_q <= '0;
        end
    end

    assign bus.block_data  = block_data_q;
    assign bus.block_valid = block_valid_q;
    assign bus.byte_cnt    = byte_cnt_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_uart_block_rx.sv
// tb/tb_uart_block_rx.sv - directed self-checking bench for uart_block_rx
module tb_uart_block_rx;
    localparam int CPB       = 16;
    localparam int BYTES     = 48;
    localparam int BLK_W     = 8 * BYTES;
    localparam int IDLE_BITS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_block_rx_if #(.BYTES(BYTES)) bus ();

    uart_block_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (62_500),
        .BYTES    (BYTES),
        .IDLE_BITS(IDLE_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int tmo_cnt   = 0;
    logic [BLK_W-1:0] cap_data = '0;
    logic [BLK_W-1:0] exp_blk  = '0;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (bus.block_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            cap_data  = bus.block_data;
        end
        if (bus.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (bus.timeout === 1'b1)   tmo_cnt  = tmo_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
        send_data(b);
        bit_time(par_v);
        bit_time(stop_v);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        send_frame(b, stop_v, ^b);
    endtask
`else
    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        send_data(b);
        bit_time(stop_v);
    endtask
`endif

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        exp_blk = {exp_blk[BLK_W-9:0], b};
    endtask

    initial begin
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check_blk("reset_block_data", bus.block_data, '0);
        check("reset_block_valid", 64'(bus.block_valid), 64'd0);
        check("reset_byte_cnt", 64'(bus.byte_cnt), 64'd0);
        check("reset_frame_err", 64'(bus.frame_err), 64'd0);
        check("reset_timeout", 64'(bus.timeout), 64'd0);
        rst = 1'b0;
        idle_cycles(2 * CPB);

        // Full block 0x00..0x2F
        for (int i = 0; i < BYTES; i++) send_good(8'(i));
        idle_cycles(4);
        check("t1_valid_pulses", 64'(valid_cnt), 64'd1);
        check_blk("t1_block", cap_data, exp_blk);
        check("t1_first_byte", 64'(cap_data[BLK_W-1 -: 8]), 64'h00);
        check("t1_last_byte", 64'(cap_data[7:0]), 64'h2F);
        check("t1_byte_cnt", 64'(bus.byte_cnt), 64'd0);
        check("t1_no_timeout", 64'(tmo_cnt), 64'd0);
        check("t1_no_frame_err", 64'(ferr_cnt), 64'd0);
        idle_cycles(3 * CPB);
        check_blk("t1_block_hold", bus.block_data, exp_blk);

        // Bad stop bit in the middle of a block
        for (int i = 0; i < 10; i++) send_good(8'(8'hC0 + i));
        send_byte(8'h55, 1'b0);
        idle_cycles(2 * CPB);
        check("t2_frame_err", 64'(ferr_cnt), 64'd1);
        check("t2_byte_cnt_kept", 64'(bus.byte_cnt), 64'd10);
        for (int i = 10; i < BYTES; i++) send_good(8'(8'hC0 + i));
        idle_cycles(4);
        check("t2_valid_pulses", 64'(valid_cnt), 64'd2);
        check_blk("t2_block", cap_data, exp_blk);
        check("t2_byte_cnt", 64'(bus.byte_cnt), 64'd0);

        // Short low glitch on the idle line during a partial block
        send_good(8'h11);
        send_good(8'h22);
        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        idle_cycles(2 * CPB);
        check("t4_byte_cnt_kept", 64'(bus.byte_cnt), 64'd2);
        check("t4_no_frame_err", 64'(ferr_cnt), 64'd1);
        check("t4_no_valid", 64'(valid_cnt), 64'd2);
        idle_cycles(IDLE_BITS * CPB + 2 * CPB);
        check("t4_timeout", 64'(tmo_cnt), 64'd1);
        check("t4_byte_cnt_zero", 64'(bus.byte_cnt), 64'd0);

        // Partial block of 5 discarded by timeout, then a clean block
        for (int i = 0; i < 5; i++) send_good(8'(8'h90 + i));
        check("t3_partial_cnt", 64'(bus.byte_cnt), 64'd5);
        idle_cycles(IDLE_BITS * CPB + 2 * CPB);
        check("t3_timeout", 64'(tmo_cnt), 64'd2);
        check("t3_byte_cnt_zero", 64'(bus.byte_cnt), 64'd0);
        for (int i = 0; i < BYTES; i++) send_good(8'(8'h30 + 3 * i));
        idle_cycles(4);
        check("t3_valid_pulses", 64'(valid_cnt), 64'd3);
        check_blk("t3_block", cap_data, exp_blk);

        // Reset during the data bits of byte 20
        for (int i = 0; i < 19; i++) send_good(8'(8'h60 + i));
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_blk("t5_rst_block_data", bus.block_data, '0);
        check("t5_rst_block_valid", 64'(bus.block_valid), 64'd0);
        check("t5_rst_byte_cnt", 64'(bus.byte_cnt), 64'd0);
        check("t5_rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("t5_rst_timeout", 64'(bus.timeout), 64'd0);
        bus.rx = 1'b1;
        rst    = 1'b0;
        idle_cycles(3 * CPB);
        for (int i = 0; i < BYTES; i++) send_good(8'(8'hA0 + i));
        idle_cycles(4);
        check("t5_valid_pulses", 64'(valid_cnt), 64'd4);
        check_blk("t5_block", cap_data, exp_blk);
        check("t5_timeouts", 64'(tmo_cnt), 64'd2);
        check("t5_frame_errs", 64'(ferr_cnt), 64'd1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity dropped, correct parity accepted
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_cycles(CPB);
        check("t6_parity_err", 64'(ferr_cnt), 64'd2);
        check("t6_parity_dropped", 64'(bus.byte_cnt), 64'd0);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_cycles(CPB);
        check("t6_parity_ok_cnt", 64'(bus.byte_cnt), 64'd1);
        check("t6_parity_ok_no_err", 64'(ferr_cnt), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
